alu_result_stage: RTL and testbench

ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

---
 rtl/alu_result_stage_if.sv | 97 +++++++++
 rtl/alu_result_stage.sv | 158 +++++++++++++++
 tb/tb_alu_result_stage.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_result_stage_if.sv
// -----------------------------------------------------------------------------
// alu_result_stage_if
//
// Purpose
//   Bundles the producer-side and consumer-side handshake signals of the ALU
//   result stage so that the stage and its environment connect with one port.
//
// Signals
//   in_data   [WIDTH-1:0]  logic-unit result offered by the producer
//   in_valid               producer has a result this cycle
//   in_ready               stage can accept a result this cycle
//   out_data  [WIDTH-1:0]  oldest buffered result
//   out_zero               zero flag of out_data
//   out_neg                sign flag of out_data
//   out_parity             even parity of out_data (ALU_RESULT_PARITY_EN only)
//   out_valid              out_data and flags are valid
//   out_ready              consumer takes out_data this cycle
//   xfer_cnt  [15:0]       completed output transfers, wraps at 16 bits
//
// Handshake (both sides): a transfer happens on a rising clk edge where
// valid && ready are both 1. The offering side keeps valid and its payload
// stable until that edge; ready never depends combinationally on valid.
//
// Modports
//   master : the environment (drives in_*, out_ready)
//   slave  : the result stage (drives in_ready, out_*, xfer_cnt)
//
// Optional feature macro: ALU_RESULT_PARITY_EN
// -----------------------------------------------------------------------------
interface alu_result_stage_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;
  logic             out_neg;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      xfer_cnt;
`ifdef ALU_RESULT_PARITY_EN
  logic             out_parity;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_zero,
    input  out_neg,
    input  out_parity,
    input  out_valid,
    output out_ready,
    input  xfer_cnt
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_zero,
    output out_neg,
    output out_parity,
    output out_valid,
    input  out_ready,
    output xfer_cnt
  );
`else
  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_zero,
    input  out_neg,
    input  out_valid,
    output out_ready,
    input  xfer_cnt
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_zero,
    output out_neg,
    output out_valid,
    input  out_ready,
    output xfer_cnt
  );
`endif

endinterface : alu_result_stage_if

// File: rtl/alu_result_stage.sv
// -----------------------------------------------------------------------------
// alu_result_stage
//
// Purpose
//   Two-entry in-order buffer sitting after the logic unit. Each accepted
//   result is stored together with its zero and sign flags (and optionally
//   its parity), computed once at push time, and presented to the consumer
//   in strict FIFO order with one cycle of latency.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; empties the buffer and clears
//              every output and the transfer counter immediately
//   bus        alu_result_stage_if.slave (in_data/in_valid/in_ready,
//              out_data/out_zero/out_neg/[out_parity]/out_valid/out_ready,
//              xfer_cnt)
//   dbg_state  current FSM state: 0 = EMPTY, 1 = ONE, 2 = FULL
//
// Handshake: push = in_valid && in_ready, pop = out_valid && out_ready, both
// taking effect on the rising clk edge. in_ready and out_valid are decoded
// from the registered state only, so neither has a combinational path from
// the opposite side of the buffer.
//
// Optional feature macro: ALU_RESULT_PARITY_EN adds out_parity, the XOR
// reduction of out_data, stored with each entry.
// -----------------------------------------------------------------------------
module alu_result_stage #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_result_stage_if.slave     bus,
  output logic [1:0]            dbg_state
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  // Entry layout: [WIDTH-1:0] data, [WIDTH] zero, [WIDTH+1] neg,
  // [WIDTH+2] parity when the parity feature is built in.
  localparam int ZERO_BIT = WIDTH;
  localparam int NEG_BIT  = WIDTH + 1;
`ifdef ALU_RESULT_PARITY_EN
  localparam int PAR_BIT  = WIDTH + 2;
  localparam int EW       = WIDTH + 3;
`else
  localparam int EW       = WIDTH + 2;
`endif

  logic [1:0]    state_q, state_d;
  // head holds the oldest entry and drives the outputs directly; tail holds
  // the second entry only while the buffer is FULL.
  logic [EW-1:0] head_q, head_d;
  logic [EW-1:0] tail_q, tail_d;
  logic [15:0]   xfer_cnt_q, xfer_cnt_d;

  logic [EW-1:0] new_entry;
  logic          in_ready;
  logic          out_valid;
  logic          push;
  logic          pop;

  // Ready/valid come from state alone.
  always_comb begin
    in_ready  = (state_q == ST_EMPTY) || (state_q == ST_ONE);
    out_valid = (state_q == ST_ONE)   || (state_q == ST_FULL);
    push      = bus.in_valid && in_ready;
    pop       = out_valid && bus.out_ready;
  end

  // Flags are derived once here and travel with the data.
  always_comb begin
    new_entry                = '0;
    new_entry[WIDTH-1:0]     = bus.in_data;
    new_entry[ZERO_BIT]      = (bus.in_data == '0);
    new_entry[NEG_BIT]       = bus.in_data[WIDTH-1];
`ifdef ALU_RESULT_PARITY_EN
    new_entry[PAR_BIT]       = ^bus.in_data;
`endif
  end

  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    tail_d     = tail_q;
    xfer_cnt_d = xfer_cnt_q;

    // 16-bit counter wraps naturally from 0xFFFF to 0x0000.
    if (pop) begin
      xfer_cnt_d = xfer_cnt_q + 16'd1;
    end

    case (state_q)
      ST_EMPTY: begin
        // Head keeps its stale contents while empty; only a push replaces it.
        if (push) begin
          head_d  = new_entry;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        case ({push, pop})
          2'b10: begin
            tail_d  = new_entry;
            state_d = ST_FULL;
          end
          2'b01: begin
            state_d = ST_EMPTY;
          end
          2'b11: begin
            // Old head leaves on this edge, new result becomes head.
            head_d  = new_entry;
          end
          default: begin
          end
        endcase
      end
      ST_FULL: begin
        // in_ready is low here, so only a pop can move the buffer.
        if (pop) begin
          head_d  = tail_q;
          state_d = ST_ONE;
        end
      end
      default: begin
        // Unreachable encoding: recover to a clean empty buffer.
        state_d = ST_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      head_q     <= '0;
      tail_q     <= '0;
      xfer_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.out_data   = head_q[WIDTH-1:0];
  assign bus.out_zero   = head_q[ZERO_BIT];
  assign bus.out_neg    = head_q[NEG_BIT];
`ifdef ALU_RESULT_PARITY_EN
  assign bus.out_parity = head_q[PAR_BIT];
`endif
  assign bus.xfer_cnt   = xfer_cnt_q;
  assign dbg_state      = state_q;

endmodule : alu_result_stage

// File: tb/tb_alu_result_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_result_stage
//
// Self-checking bench for alu_result_stage (WIDTH = 8). A reference model
// tracks the buffer as a queue of expected entries: an entry is pushed when
// the inputs offer a result the model can accept, and popped and compared
// when the consumer takes one. Scenario tasks add targeted inline checks.
// Build with ALU_RESULT_PARITY_EN defined to cover the parity output.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_alu_result_stage;

  localparam int WIDTH = 8;
`ifdef ALU_RESULT_PARITY_EN
  localparam int EW = WIDTH + 3;
`else
  localparam int EW = WIDTH + 2;
`endif

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_result_stage_if #(.WIDTH(WIDTH)) bus ();
  logic [1:0] dbg_state;

  alu_result_stage #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int          chk_cnt  = 0;
  int          fail_cnt = 0;
  logic [EW-1:0] exp_q[$];
  logic [15:0] exp_xfer = 16'd0;

  // Expected entry built from the spec: flags {parity, neg, zero, data}.
  function automatic logic [EW-1:0] model_entry(input logic [WIDTH-1:0] d);
    logic [EW-1:0] e;
    e             = '0;
    e[WIDTH-1:0]  = d;
    e[WIDTH]      = (d == 8'h00);
    e[WIDTH+1]    = d[7];
`ifdef ALU_RESULT_PARITY_EN
    e[WIDTH+2]    = ^d;
`endif
    return e;
  endfunction

  function automatic logic [EW-1:0] observed_entry();
    logic [EW-1:0] e;
    e             = '0;
    e[WIDTH-1:0]  = bus.out_data;
    e[WIDTH]      = bus.out_zero;
    e[WIDTH+1]    = bus.out_neg;
`ifdef ALU_RESULT_PARITY_EN
    e[WIDTH+2]    = bus.out_parity;
`endif
    return e;
  endfunction

  // ---------------------------------------------------------------- scoreboard
  always @(negedge rst_n) begin
    exp_q.delete();
    exp_xfer = 16'd0;
  end

  always @(negedge clk) begin : scoreboard
    logic          m_ready;
    logic          m_valid;
    logic [1:0]    m_state;
    logic [EW-1:0] got;
    if (rst_n === 1'b1) begin
      m_ready = (exp_q.size() < 2);
      m_valid = (exp_q.size() > 0);
      m_state = 2'(exp_q.size());

      chk_cnt++;
      if (bus.in_ready !== m_ready) begin
        fail_cnt++;
        $display("FAIL sb_in_ready t=%0t: got %b expected %b", $time, bus.in_ready, m_ready);
      end
      chk_cnt++;
      if (bus.out_valid !== m_valid) begin
        fail_cnt++;
        $display("FAIL sb_out_valid t=%0t: got %b expected %b", $time, bus.out_valid, m_valid);
      end
      chk_cnt++;
      if (dbg_state !== m_state) begin
        fail_cnt++;
        $display("FAIL sb_state t=%0t: got %0d expected %0d", $time, dbg_state, m_state);
      end
      chk_cnt++;
      if (bus.xfer_cnt !== exp_xfer) begin
        fail_cnt++;
        $display("FAIL sb_xfer_cnt t=%0t: got %h expected %h", $time, bus.xfer_cnt, exp_xfer);
      end
      if (m_valid) begin
        got = observed_entry();
        chk_cnt++;
        if (got !== exp_q[0]) begin
          fail_cnt++;
          $display("FAIL sb_entry t=%0t: got %h expected %h", $time, got, exp_q[0]);
        end
        if (bus.out_ready === 1'b1) begin
          void'(exp_q.pop_front());
          exp_xfer = exp_xfer + 16'd1;
        end
      end
      if (bus.in_valid === 1'b1 && m_ready) begin
        exp_q.push_back(model_entry(bus.in_data));
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic r);
    @(posedge clk);
    #1;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b0);
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    chk_cnt++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      fail_cnt++;
      $display("FAIL reset_hs: got valid=%b ready=%b expected valid=0 ready=1", bus.out_valid, bus.in_ready);
    end
    chk_cnt++;
    if (bus.out_data !== 8'h00 || bus.out_zero !== 1'b0 || bus.out_neg !== 1'b0) begin
      fail_cnt++;
      $display("FAIL reset_out: got data=%h z=%b n=%b expected 00/0/0", bus.out_data, bus.out_zero, bus.out_neg);
    end
`ifdef ALU_RESULT_PARITY_EN
    chk_cnt++;
    if (bus.out_parity !== 1'b0) begin
      fail_cnt++;
      $display("FAIL reset_parity: got %b expected 0", bus.out_parity);
    end
`endif
    chk_cnt++;
    if (bus.xfer_cnt !== 16'h0000 || dbg_state !== 2'd0) begin
      fail_cnt++;
      $display("FAIL reset_cnt_state: got cnt=%h state=%0d expected 0000/0", bus.xfer_cnt, dbg_state);
    end
    // Release between edges and offer a result at once: taken on first edge.
    @(posedge clk);
    #3;
    rst_n        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h3C;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h3C) begin
      fail_cnt++;
      $display("FAIL first_push: got valid=%b data=%h expected 1/3c", bus.out_valid, bus.out_data);
    end
    drain();
  endtask

  task automatic test_zero_flag();
    logic [15:0] base;
    drive(1'b1, 8'h00, 1'b1);
    base = exp_xfer;
    drive(1'b0, 8'h00, 1'b1);
    @(negedge clk);
    chk_cnt++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h00 || bus.out_zero !== 1'b1 || bus.out_neg !== 1'b0) begin
      fail_cnt++;
      $display("FAIL zero_push: got v=%b d=%h z=%b n=%b expected 1/00/1/0",
               bus.out_valid, bus.out_data, bus.out_zero, bus.out_neg);
    end
    @(posedge clk);
    #1;
    chk_cnt++;
    if (bus.xfer_cnt !== base + 16'd1 || bus.out_valid !== 1'b0) begin
      fail_cnt++;
      $display("FAIL zero_pop_cnt: got cnt=%h v=%b expected %h/0", bus.xfer_cnt, bus.out_valid, base + 16'd1);
    end
    drain();
  endtask

  task automatic test_backpressure();
    drive(1'b1, 8'hFF, 1'b0);
    drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, 8'hAA, 1'b0);
    @(negedge clk);
    chk_cnt++;
    if (bus.in_ready !== 1'b0 || dbg_state !== 2'd2) begin
      fail_cnt++;
      $display("FAIL bp_full: got ready=%b state=%0d expected 0/2", bus.in_ready, dbg_state);
    end
    drive(1'b0, 8'h00, 1'b1);
    @(negedge clk);
    chk_cnt++;
    if (bus.out_data !== 8'hFF || bus.out_neg !== 1'b1 || dbg_state !== 2'd2) begin
      fail_cnt++;
      $display("FAIL bp_first: got d=%h n=%b state=%0d expected ff/1/2", bus.out_data, bus.out_neg, dbg_state);
    end
    drive(1'b0, 8'h00, 1'b1);
    @(negedge clk);
    chk_cnt++;
    if (bus.out_data !== 8'h55 || bus.out_neg !== 1'b0 || bus.out_valid !== 1'b1) begin
      fail_cnt++;
      $display("FAIL bp_second: got d=%h n=%b v=%b expected 55/0/1", bus.out_data, bus.out_neg, bus.out_valid);
    end
    drive(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk_cnt++;
    if (bus.out_valid !== 1'b0 || dbg_state !== 2'd0 || bus.out_data !== 8'h55) begin
      fail_cnt++;
      $display("FAIL bp_empty_hold: got v=%b state=%0d d=%h expected 0/0/55", bus.out_valid, dbg_state, bus.out_data);
    end
  endtask

  task automatic test_simultaneous();
    drive(1'b1, 8'hAA, 1'b0);
    drive(1'b1, 8'h01, 1'b1);
    @(negedge clk);
    chk_cnt++;
    if (bus.out_data !== 8'hAA || dbg_state !== 2'd1) begin
      fail_cnt++;
      $display("FAIL sim_old: got d=%h state=%0d expected aa/1", bus.out_data, dbg_state);
    end
    drive(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk_cnt++;
    if (bus.out_data !== 8'h01 || dbg_state !== 2'd1 || bus.out_valid !== 1'b1) begin
      fail_cnt++;
      $display("FAIL sim_new: got d=%h state=%0d v=%b expected 01/1/1", bus.out_data, dbg_state, bus.out_valid);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 8'h80, 1'b0);
    drive(1'b1, 8'h7F, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_cnt++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.xfer_cnt !== 16'h0000) begin
      fail_cnt++;
      $display("FAIL rst_mid_hs: got v=%b r=%b cnt=%h expected 0/1/0000", bus.out_valid, bus.in_ready, bus.xfer_cnt);
    end
    chk_cnt++;
    if (bus.out_data !== 8'h00 || bus.out_neg !== 1'b0 || dbg_state !== 2'd0) begin
      fail_cnt++;
      $display("FAIL rst_mid_out: got d=%h n=%b state=%0d expected 00/0/0", bus.out_data, bus.out_neg, dbg_state);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 65537; i++) drive(1'b1, 8'($urandom_range(0, 255)), 1'b1);
    drive(1'b0, 8'h00, 1'b1);
    @(posedge clk);
    @(negedge clk);
    chk_cnt++;
    if (bus.xfer_cnt !== 16'h0001 || bus.out_valid !== 1'b0) begin
      fail_cnt++;
      $display("FAIL wrap_cnt: got cnt=%h v=%b expected 0001/0", bus.xfer_cnt, bus.out_valid);
    end
    drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++)
      drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    drain();
    @(negedge clk);
    chk_cnt++;
    if (exp_q.size() != 0 || bus.out_valid !== 1'b0) begin
      fail_cnt++;
      $display("FAIL rand_drained: got model=%0d v=%b expected 0/0", exp_q.size(), bus.out_valid);
    end
  endtask

`ifdef ALU_RESULT_PARITY_EN
  task automatic test_parity();
    drive(1'b1, 8'b10101010, 1'b1);
    drive(1'b1, 8'b00000111, 1'b1);
    @(negedge clk);
    chk_cnt++;
    if (bus.out_parity !== 1'b0 || bus.out_data !== 8'hAA) begin
      fail_cnt++;
      $display("FAIL parity_aa: got p=%b d=%h expected 0/aa", bus.out_parity, bus.out_data);
    end
    drive(1'b0, 8'h00, 1'b1);
    @(negedge clk);
    chk_cnt++;
    if (bus.out_parity !== 1'b1 || bus.out_data !== 8'h07) begin
      fail_cnt++;
      $display("FAIL parity_07: got p=%b d=%h expected 1/07", bus.out_parity, bus.out_data);
    end
    drain();
  endtask
`endif

  // ---------------------------------------------------------------- watchdog
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // ---------------------------------------------------------------- sequence
  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;
    #12;
    test_reset();
    test_zero_flag();
    test_backpressure();
    test_simultaneous();
    test_reset_mid();
    test_wrap();
    test_random();
`ifdef ALU_RESULT_PARITY_EN
    test_parity();
`endif
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", chk_cnt, fail_cnt);
    $finish;
  end

endmodule : tb_alu_result_stage
